// File: rtl/ccu_snoop_bcast_pkg.sv
// Shared ACE snoop channel types and CR response bit positions for the snoop
// broadcast/merge stage.
package ccu_snoop_bcast_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned RespWidth = 5;

    // CRRESP bit positions: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    localparam int unsigned RespWasUnique    = 4;
    localparam int unsigned RespIsShared     = 3;
    localparam int unsigned RespPassDirty    = 2;
    localparam int unsigned RespError        = 1;
    localparam int unsigned RespDataTransfer = 0;

    typedef logic [RespWidth-1:0] crresp_t;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [3:0]           snoop;
        logic [2:0]           prot;
    } ace_ac_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 last;
    } ace_cd_chan_t;

endpackage

// File: rtl/ccu_snoop_bcast_lzc.sv
// Trailing-zero counter: index of the lowest set bit, empty_o when no bit set.
module ccu_snoop_bcast_lzc #(
    parameter int unsigned Width = 4,
    localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] in_i,
    output logic [CntW-1:0]  cnt_o,
    output logic             empty_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (in_i[i]) cnt_o = CntW'(i);
        end
        empty_o = ~|in_i;
    end

endmodule

// File: rtl/ccu_snoop_bcast.sv
// Forks one AC snoop to the targeted caches, OR-merges their CR responses and
// forwards a single CD burst upstream while draining the redundant ones.
module ccu_snoop_bcast
    import ccu_snoop_bcast_pkg::*;
#(
    parameter int unsigned NoMst = 4,
    parameter type ac_chan_t = ccu_snoop_bcast_pkg::ace_ac_chan_t,
    parameter type cd_chan_t = ccu_snoop_bcast_pkg::ace_cd_chan_t,
    parameter type domain_mask_t = logic [NoMst-1:0]
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ac_valid_i,
    output logic                  ac_ready_o,
    input  ac_chan_t              ac_i,
    input  domain_mask_t          domain_mask_i,
    output logic                  cr_valid_o,
    input  logic                  cr_ready_i,
    output crresp_t               cr_resp_o,
    output logic                  cd_valid_o,
    input  logic                  cd_ready_i,
    output cd_chan_t              cd_o,
    output logic [NoMst-1:0]      mst_ac_valid_o,
    input  logic [NoMst-1:0]      mst_ac_ready_i,
    output ac_chan_t [NoMst-1:0]  mst_ac_o,
    input  logic [NoMst-1:0]      mst_cr_valid_i,
    output logic [NoMst-1:0]      mst_cr_ready_o,
    input  crresp_t [NoMst-1:0]   mst_cr_resp_i,
    input  logic [NoMst-1:0]      mst_cd_valid_i,
    output logic [NoMst-1:0]      mst_cd_ready_o,
    input  cd_chan_t [NoMst-1:0]  mst_cd_i
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSnoop = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;
    localparam logic [1:0] StData  = 2'd3;
    localparam int unsigned SelW = (NoMst > 1) ? $clog2(NoMst) : 1;

    logic [1:0]       state_d, state_q;
    ac_chan_t         ac_d, ac_q;
    logic [NoMst-1:0] mask_d, mask_q;
    logic [NoMst-1:0] ac_done_d, ac_done_q;
    logic [NoMst-1:0] cr_done_d, cr_done_q;
    logic [NoMst-1:0] dt_d, dt_q;
    logic [NoMst-1:0] cd_done_d, cd_done_q;
    crresp_t          resp_d, resp_q;
    logic [SelW-1:0]  sel_d, sel_q, sel_nxt;
    logic             sel_empty;

    logic [NoMst-1:0] ac_hs, cr_hs, cd_hs, cr_dt, cd_last, dt_snoop;
    logic             in_snoop, in_data, drain_ph;

    assign in_snoop = (state_q == StSnoop);
    assign in_data  = (state_q == StData);
    assign drain_ph = (state_q == StResp) || in_data;

    assign ac_ready_o     = (state_q == StIdle);
    assign cr_valid_o     = (state_q == StResp);
    assign cr_resp_o      = resp_q;
    assign mst_ac_o       = {NoMst{ac_q}};
    // CR ready follows the registered ac_done, so a CR never lands with its own AC.
    assign mst_ac_valid_o = in_snoop ? (mask_q & ~ac_done_q) : '0;
    assign mst_cr_ready_o = in_snoop ? (ac_done_q & ~cr_done_q) : '0;

    assign ac_hs    = mst_ac_valid_o & mst_ac_ready_i;
    assign cr_hs    = mst_cr_valid_i & mst_cr_ready_o;
    assign cd_hs    = mst_cd_valid_i & mst_cd_ready_o;
    assign dt_snoop = dt_q | (cr_hs & cr_dt);

    always_comb begin
        for (int i = 0; i < NoMst; i++) begin
            cr_dt[i]   = mst_cr_resp_i[i][RespDataTransfer];
            cd_last[i] = mst_cd_i[i].last;
        end
    end

    ccu_snoop_bcast_lzc #(.Width(NoMst)) i_lzc (
        .in_i    (dt_snoop),
        .cnt_o   (sel_nxt),
        .empty_o (sel_empty)
    );

    // Redundant data holders are drained from SNOOP exit; the selected one is a pure pass-through.
    always_comb begin
        mst_cd_ready_o = '0;
        if (drain_ph) mst_cd_ready_o = dt_q & ~cd_done_q;
        mst_cd_ready_o[sel_q] = in_data && cd_ready_i && !cd_done_q[sel_q];
        cd_valid_o = in_data && mst_cd_valid_i[sel_q] && !cd_done_q[sel_q];
        cd_o       = mst_cd_i[sel_q];
    end

    always_comb begin
        state_d   = state_q;
        ac_d      = ac_q;
        mask_d    = mask_q;
        ac_done_d = ac_done_q;
        cr_done_d = cr_done_q;
        dt_d      = dt_q;
        cd_done_d = cd_done_q;
        resp_d    = resp_q;
        sel_d     = sel_q;
        case (state_q)
            StIdle: begin
                if (ac_valid_i) begin
                    ac_d      = ac_i;
                    mask_d    = domain_mask_i;
                    ac_done_d = '0;
                    cr_done_d = '0;
                    dt_d      = '0;
                    cd_done_d = '0;
                    resp_d    = '0;
                    sel_d     = '0;
                    state_d   = (domain_mask_i == '0) ? StResp : StSnoop;
                end
            end
            StSnoop: begin
                ac_done_d = ac_done_q | ac_hs;
                cr_done_d = cr_done_q | cr_hs;
                dt_d      = dt_snoop;
                for (int i = 0; i < NoMst; i++) begin
                    if (cr_hs[i]) resp_d = resp_d | mst_cr_resp_i[i];
                end
                if (cr_done_d == mask_q) begin
                    state_d                  = StResp;
                    sel_d                    = sel_nxt;
                    resp_d[RespDataTransfer] = !sel_empty;
                end
            end
            StResp: begin
                cd_done_d = cd_done_q | (cd_hs & cd_last);
                if (cr_ready_i) state_d = (dt_q == '0) ? StIdle : StData;
            end
            default: begin
                cd_done_d = cd_done_q | (cd_hs & cd_last);
                if (cd_done_d == dt_q) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ac_q      <= '0;
            mask_q    <= '0;
            ac_done_q <= '0;
            cr_done_q <= '0;
            dt_q      <= '0;
            cd_done_q <= '0;
            resp_q    <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            ac_q      <= ac_d;
            mask_q    <= mask_d;
            ac_done_q <= ac_done_d;
            cr_done_q <= cr_done_d;
            dt_q      <= dt_d;
            cd_done_q <= cd_done_d;
            resp_q    <= resp_d;
            sel_q     <= sel_d;
        end
    end

endmodule
